sha256_stream_core: RTL and testbench
=====================================

// Module: sha256_stream_core
// PURPOSE
//  Multi-block SHA-256 compression engine with valid/ready handshakes on both sides.
//  Accepts pre-padded 512-bit blocks and chains the hash state across the blocks of one message.
//  Returns the 256-bit digest after the last block of the message.
//  Sits between the padding/packing front end and the result FIFO.
//  Unrolls ROUNDS_PER_CYCLE rounds per clock and uses a rolling 16-word schedule window instead of a 64-word array.
// PARAMETERS
//  ROUNDS_PER_CYCLE  1  rounds per clock; legal values 1,2,4,8; N = 64/ROUNDS_PER_CYCLE compression cycles per block
// PORTS
//  clk           in   1    single clock, rising edge
//  reset_n       in   1    asynchronous, active-low reset
//  blk_valid     in   1    blk_* fields are valid
//  blk_ready     out  1    core can accept a block
//  blk_data      in   512  padded block, big-endian; W0 = blk_data[511:480], W15 = blk_data[31:0]
//  blk_first     in   1    block starts a message; chaining state is loaded from IV
//  blk_last      in   1    block ends a message; a digest is produced
//  digest_valid  out  1    digest holds a finished hash
//  digest_ready  in   1    downstream consumes the digest
//  digest        out  256  {H0..H7}
//  busy          out  1    state != IDLE
// BEHAVIOUR
//  Reset values:
//   - state = IDLE; blk_ready = 1 once reset_n is high (0 while reset_n is low)
//   - digest_valid = 0, digest = 0, busy = 0, H = IV
//  A transfer occurs on a rising edge when blk_valid && blk_ready.
//  FSM:
//   - IDLE: blk_ready = 1. On a transfer: a..h <= (blk_first ? IV : H); W window <= blk_data; rnd <= 0 -> ROUND.
//   - ROUND: each edge runs rounds rnd..rnd+R-1 and adds R to rnd; leaves for FINAL after N edges (rnd reaches 64).
//   - FINAL: Hi <= (blk_first_q ? IVi : Hi) + a..h, mod 2^32 -> OUT if blk_last_q, else -> IDLE.
//   - OUT: digest_valid = 1, blk_ready = 0. digest_ready -> IDLE.
//  Rules:
//   - blk_first and blk_last are registered at the transfer. blk_first && blk_last is a single-block message.
//   - Schedule: W_t (t >= 16) = s1(W_t-2) + W_t-7 + s0(W_t-15) + W_t-16. R new words per cycle, chained combinationally; the window shifts by R.
//   - Latency: digest_valid rises N+1 edges after the accepting edge (65 for R=1, 9 for R=8).
//   - Peak throughput: one block every N+2 cycles.
//   - digest and digest_valid stay stable while digest_valid && !digest_ready.
//   - blk_first on any block discards the chain in progress. A non-first block after reset chains from IV.
//   - A transfer is impossible outside IDLE, so simultaneous accept and output cannot occur.
//   - reset_n low mid-block or mid-OUT: everything returns immediately to reset values; the partial message is lost.
//   - All additions are 32-bit and wrap modulo 2^32; no carry leaves a word.
// CONFIGURATION
//  SHA256_SHA224_MODE_EN:
//   - Defined: adds input mode_224 (1 bit), sampled with blk_first.
//   - When mode_224 was set, the IV is the SHA-224 IV, digest[255:32] = H0..H6 and digest[31:0] = 0.
//   - Undefined: the port is absent and the core is SHA-256 only.
// STRUCTURE
//  sha256_pkg holds:
//   - K[0:63] constant table and the SHA-256 and SHA-224 IV constants
//   - functions S0, S1, s0, s1, ch, maj
//   - state enum: IDLE, ROUND, FINAL, OUT
//  Sub-module sha256_round: one combinational round taking {a..h}, K and W and returning the next {a..h}.
//  The core instantiates sha256_round ROUNDS_PER_CYCLE times in a generate loop.
// TESTING
//  - "abc" single block (first = last = 1) -> digest ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad; R=1 latency 65.
//  - Empty message -> e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
//  - 448-bit "abcdbcdecdefdefg...nopq" as two blocks (first, then last) -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1. No digest after block 1.
//  - digest_ready held low for 20 cycles with blk_valid high -> digest stable, blk_ready = 0, no new block taken. Release -> next block accepted in IDLE.
//  - reset_n pulsed low at ROUND cycle 30 -> outputs at reset values at once. A following "abc" still gives the correct digest.
//  - R=8 rerun of the tests above -> same digests, latency 9. With SHA256_SHA224_MODE_EN, mode_224 and "abc" -> 23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7 in digest[255:32].

Source files
------------

// File: rtl/sha256_pkg.sv
// SHA-256 constants, round helper functions and FSM state encoding shared by the core and its round stage.
// The SHA-224 IV lives here unconditionally so the mode option only touches the core.
package sha256_pkg;

    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t ROUND = 2'd1;
    localparam state_t FINAL = 2'd2;
    localparam state_t OUT   = 2'd3;

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] S0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] S1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: {a..h} in, next {a..h} out.
// Zero latency; no flow control of its own.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] state_in,
    input  logic [31:0]  k,
    input  logic [31:0]  w,
    output logic [255:0] state_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = state_in;
    assign t1 = h + S1(e) + ch(e, f, g) + k + w;
    assign t2 = S0(a) + maj(a, b, c);
    assign state_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 engine, ROUNDS_PER_CYCLE rounds per clock; optional SHA-224 via SHA256_SHA224_MODE_EN.
// Latency: digest_valid N+1 edges after block accept (N = 64/ROUNDS_PER_CYCLE); one block per N+2 cycles.
// Backpressure: blk_ready only in IDLE; digest held stable until digest_ready.
module sha256_stream_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
)(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
`ifdef SHA256_SHA224_MODE_EN
    input  logic         mode_224,
`endif
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest,
    output logic         busy
);

    localparam int         R        = ROUNDS_PER_CYCLE;
    localparam logic [6:0] LAST_RND = 7'(64 - R);

    state_t       state;
    logic [6:0]   rnd;
    logic [255:0] work;
    logic [255:0] h;
    logic [31:0]  win [0:15];
    logic [31:0]  ext [0:15+R];
    logic         first_q;
    logic         last_q;
    logic [255:0] digest_q;
    logic [255:0] iv_load;
    logic [255:0] iv_q;
    logic [255:0] h_base;
    logic [255:0] h_new;
    logic [255:0] dig_new;

`ifdef SHA256_SHA224_MODE_EN
    logic mode_q;
    assign iv_load = mode_224 ? IV224 : IV256;
    assign iv_q    = mode_q   ? IV224 : IV256;
    assign dig_new = mode_q ? {h_new[255:32], 32'h0} : h_new;
`else
    assign iv_load = IV256;
    assign iv_q    = IV256;
    assign dig_new = h_new;
`endif

    // Rounds chain through per-stage wires so each stage sees the previous stage's output directly.
    for (genvar i = 0; i < R; i++) begin : g_rnd
        logic [5:0]   kidx;
        logic [255:0] rin;
        logic [255:0] rout;
        assign kidx = rnd[5:0] + 6'(i);
        if (i == 0) begin : g_head
            assign rin = work;
        end else begin : g_tail
            assign rin = g_rnd[i-1].rout;
        end
        sha256_round u_round (
            .state_in  (rin),
            .k         (K[kidx]),
            .w         (win[i]),
            .state_out (rout)
        );
    end

    // ext holds the live window followed by R freshly scheduled words; the window then slides by R.
    always_comb begin
        for (int j = 0; j < 16 + R; j++) begin
            ext[j] = '0;
        end
        for (int j = 0; j < 16; j++) begin
            ext[j] = win[j];
        end
        for (int j = 0; j < R; j++) begin
            ext[16+j] = s1(ext[14+j]) + ext[9+j] + s0(ext[1+j]) + ext[j];
        end
    end

    always_comb begin
        h_base = first_q ? iv_q : h;
        h_new  = '0;
        for (int j = 0; j < 8; j++) begin
            h_new[255-32*j -: 32] = h_base[255-32*j -: 32] + work[255-32*j -: 32];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rnd      <= '0;
            work     <= '0;
            h        <= IV256;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            digest_q <= '0;
`ifdef SHA256_SHA224_MODE_EN
            mode_q   <= 1'b0;
`endif
            for (int j = 0; j < 16; j++) begin
                win[j] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (blk_valid) begin
                        work    <= blk_first ? iv_load : h;
                        rnd     <= '0;
                        first_q <= blk_first;
                        last_q  <= blk_last;
`ifdef SHA256_SHA224_MODE_EN
                        if (blk_first) begin
                            mode_q <= mode_224;
                        end
`endif
                        for (int j = 0; j < 16; j++) begin
                            win[j] <= blk_data[511-32*j -: 32];
                        end
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    work <= g_rnd[R-1].rout;
                    rnd  <= rnd + 7'(R);
                    for (int j = 0; j < 16; j++) begin
                        win[j] <= ext[j+R];
                    end
                    if (rnd == LAST_RND) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    h <= h_new;
                    if (last_q) begin
                        digest_q <= dig_new;
                        state    <= OUT;
                    end else begin
                        state <= IDLE;
                    end
                end
                OUT: begin
                    if (digest_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign blk_ready    = (state == IDLE) && reset_n;
    assign digest_valid = (state == OUT);
    assign digest       = digest_q;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_sha256_stream_core.sv
// Scoreboard bench for sha256_stream_core: known-answer digests, latency, throughput, stall and mid-block reset.
module tb_sha256_stream_core;

    localparam int RPC    = 1;
    localparam int N      = 64 / RPC;
    localparam int RST_AT = (N > 30) ? 30 : N / 2;

    localparam logic [511:0] MSG_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] MSG_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] MSG_B1 =
        512'h61626364_62636465_63646566_64656667_65666768_66676869_6768696a_68696a6b_696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f_6d6e6f70_6e6f7071_80000000_00000000;
    localparam logic [511:0] MSG_B2 = {480'h0, 32'h000001c0};

    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] D_2B    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         blk_valid = 1'b0;
    logic [511:0] blk_data = '0;
    logic         blk_first = 1'b0;
    logic         blk_last = 1'b0;
    logic         digest_ready = 1'b1;
    logic         blk_ready;
    logic         digest_valid;
    logic [255:0] digest;
    logic         busy;
`ifdef SHA256_SHA224_MODE_EN
    logic         mode_224 = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int ncyc = 0;
    int last_acc = 0;
    int ndig = 0;
    int nexp = 0;
    logic [255:0] sb [$];
    logic [255:0] exp_d;
    logic         prev_dv = 1'b0;

    sha256_stream_core #(.ROUNDS_PER_CYCLE(RPC)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .blk_data     (blk_data),
        .blk_first    (blk_first),
        .blk_last     (blk_last),
`ifdef SHA256_SHA224_MODE_EN
        .mode_224     (mode_224),
`endif
        .digest_valid (digest_valid),
        .digest_ready (digest_ready),
        .digest       (digest),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ncyc++;

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Monitor: latency on each rising digest_valid, scoreboard pop on each handshake.
    always @(negedge clk) begin
        if (reset_n) begin
            if (digest_valid && !prev_dv) begin
                check_val("latency", 256'(ncyc - last_acc), 256'(N + 1));
            end
            if (digest_valid && digest_ready) begin
                if (sb.size() == 0) begin
                    check_val("spurious_digest", 256'(sb.size()), 256'(1));
                end else begin
                    exp_d = sb.pop_front();
                    check_val("digest", digest, exp_d);
                    ndig++;
                end
            end
        end
        prev_dv = digest_valid;
    end

    task automatic wait_accept(input logic [255:0] exp, output int acc);
        bit done = 0;
        int t = 0;
        acc = 0;
        while (!done && t < 400) begin
            @(negedge clk);
            if (blk_ready) begin
                done = 1;
                acc  = ncyc + 1;
                if (blk_last) begin
                    sb.push_back(exp);
                    nexp++;
                    last_acc = acc;
                end
            end
            t++;
        end
        if (!done) check_val("accept_timeout", 256'(t), 256'(0));
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
    endtask

    task automatic send(input logic [511:0] d, input logic f, input logic l,
                        input logic [255:0] exp, output int acc);
        blk_data  = d;
        blk_first = f;
        blk_last  = l;
        blk_valid = 1'b1;
        wait_accept(exp, acc);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_val("drain", 256'(sb.size()), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a1, a2, bad;
        logic [255:0] snap;

        #12;
        check_val("rst_blk_ready", 256'(blk_ready), 256'(0));
        check_val("rst_digest_valid", 256'(digest_valid), 256'(0));
        check_val("rst_busy", 256'(busy), 256'(0));
        check_val("rst_digest", digest, 256'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check_val("rel_blk_ready", 256'(blk_ready), 256'(1));
        @(posedge clk);
        #1;

        send(MSG_ABC, 1'b1, 1'b1, D_ABC, a1);
        wait_drain();
        send(MSG_EMPTY, 1'b1, 1'b1, D_EMPTY, a1);
        wait_drain();

        // Two-block message back to back: also the peak-throughput spacing.
        send(MSG_B1, 1'b1, 1'b0, 256'h0, a1);
        send(MSG_B2, 1'b0, 1'b1, D_2B, a2);
        check_val("throughput", 256'(a2 - a1), 256'(N + 2));
        wait_drain();

        // A first block abandons the chain left by an unfinished message.
        send(MSG_B1, 1'b1, 1'b0, 256'h0, a1);
        send(MSG_ABC, 1'b1, 1'b1, D_ABC, a1);
        wait_drain();

        // Downstream stall with another block pending.
        digest_ready = 1'b0;
        send(MSG_ABC, 1'b1, 1'b1, D_ABC, a1);
        blk_data  = MSG_EMPTY;
        blk_first = 1'b1;
        blk_last  = 1'b1;
        blk_valid = 1'b1;
        for (int t = 0; t < N + 20 && !digest_valid; t++) begin
            @(posedge clk);
            #1;
        end
        check_val("stall_dv", 256'(digest_valid), 256'(1));
        snap = digest;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (digest !== snap || blk_ready !== 1'b0 || digest_valid !== 1'b1) bad++;
        end
        check_val("stall_stable", 256'(bad), 256'(0));
        @(posedge clk);
        #1;
        digest_ready = 1'b1;
        wait_accept(D_EMPTY, a1);
        wait_drain();

        // Reset in the middle of the round phase.
        send(MSG_ABC, 1'b1, 1'b1, D_ABC, a1);
        repeat (RST_AT - 1) @(posedge clk);
        #1;
        check_val("busy_round", 256'(busy), 256'(1));
        reset_n = 1'b0;
        nexp -= sb.size();
        sb.delete();
        #1;
        check_val("mid_rst_digest_valid", 256'(digest_valid), 256'(0));
        check_val("mid_rst_busy", 256'(busy), 256'(0));
        check_val("mid_rst_blk_ready", 256'(blk_ready), 256'(0));
        check_val("mid_rst_digest", digest, 256'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        // Non-first block straight after reset must chain from the IV.
        send(MSG_ABC, 1'b0, 1'b1, D_ABC, a1);
        wait_drain();

`ifdef SHA256_SHA224_MODE_EN
        mode_224 = 1'b1;
        send(MSG_ABC, 1'b1, 1'b1,
             {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0}, a1);
        mode_224 = 1'b0;
        wait_drain();
        send(MSG_ABC, 1'b1, 1'b1, D_ABC, a1);
        wait_drain();
`endif

        check_val("digest_count", 256'(ndig), 256'(nexp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
